// File: rtl/uart_loader.sv
// uart_loader: UART program-download engine acting as an extra bus master.
// It receives a framed byte stream on rx_pin: A5, LEN_L, LEN_H, LEN payload bytes, and an
// optional checksum byte. While the download runs it holds the core in halt. It writes the
// payload as little-endian 32-bit words from BASE_ADDR upward. On success it drops halt and
// pulses reset_req_o for one cycle.
//
// Optional feature macro: UART_LOADER_CSUM_EN. When it is defined, a trailing byte equal to
// the modulo-256 sum of the payload is required after the payload.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   rx_pin       UART RX (idle high, 8N1, LSB first)
//   mem_req_o    bus write request, held until acknowledged
//   mem_we_o     write enable (mirrors mem_req_o)
//   mem_addr_o   write address
//   mem_wdata_o  write data
//   mem_ack_i    bus acknowledge for the current request
//   halt_req_o   core halt while a frame is in progress
//   reset_req_o  one-cycle core reset pulse after a successful download
//   busy_o       engine not idle
//   err_o        sticky error flag, cleared by the next sync byte
module uart_loader #(
  parameter int unsigned CLK_DIV   = 434,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 32'd5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  output logic        halt_req_o,
  output logic        reset_req_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned     CntW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]      SyncByte = 8'hA5;

  // ---------------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;

  rx_st_e          rx_st_q, rx_st_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;
  logic [7:0]      rx_byte;

  assign rx_byte = rx_shift_q;

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_st_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_st_d  = RxStart;
          rx_cnt_d = HalfLoad;
        end
      end
      RxStart: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else if (rx_sync_q) begin
          rx_st_d = RxIdle;  // line went back high: glitch, not a start bit
        end else begin
          rx_st_d  = RxData;
          rx_cnt_d = BitLoad;
          rx_bit_d = '0;
        end
      end
      RxData: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BitLoad;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
          rx_st_d    = RxIdle;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_pin;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and bus master
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;  // payload bytes still to receive
  logic [31:0] word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        pend_q, pend_d;  // word queued behind a request acked in the same cycle
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
  logic [31:0] tmo_q, tmo_d;
  logic        csum_got_q, csum_got_d;
  logic        csum_bad_q, csum_bad_d;

  logic        in_frame, wr_idle, go_err, last_byte;
  logic [31:0] word_nxt;

  assign in_frame  = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCsum);
  assign wr_idle   = !req_q && !pend_q;
  assign last_byte = (len_q == 16'd1);
  assign word_nxt  = word_q | ({24'h0, rx_byte} << {bidx_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    bidx_d     = bidx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_d      = req_q;
    pend_d     = pend_q;
    sum_d      = sum_q;
    err_d      = err_q;
    tmo_d      = '0;
    csum_got_d = csum_got_q;
    csum_bad_d = csum_bad_q;
    go_err     = 1'b0;

    // The address advances on each accepted write, so it always names the next word.
    if (req_q && mem_ack_i) begin
      req_d  = 1'b0;
      addr_d = addr_q + 32'd4;
    end
    if (pend_q) begin
      req_d  = 1'b1;
      pend_d = 1'b0;
    end

    if (in_frame) begin
      tmo_d = rx_valid_q ? '0 : tmo_q + 32'd1;
      if (tmo_q >= TIMEOUT) go_err = 1'b1;
      if (rx_ferr_q) go_err = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid_q && (rx_byte == SyncByte)) begin
          state_d    = StLen0;
          err_d      = 1'b0;
          sum_d      = '0;
          addr_d     = BASE_ADDR;
          word_d     = '0;
          bidx_d     = '0;
          csum_got_d = 1'b0;
          csum_bad_d = 1'b0;
        end
      end
      StLen0: begin
        if (rx_valid_q) begin
          len_d   = {8'h00, rx_byte};
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (rx_valid_q) begin
          len_d   = {rx_byte, len_q[7:0]};
          state_d = ({rx_byte, len_q[7:0]} == 16'd0) ? StDone : StData;
        end
      end
      StData: begin
        if (len_q == '0) begin
          // All bytes in; hold here until the last write is accepted.
          if (wr_idle) state_d = StDone;
        end else if (rx_valid_q) begin
          sum_d  = sum_q + rx_byte;
          len_d  = len_q - 16'd1;
          bidx_d = bidx_q + 2'd1;
          word_d = word_nxt;
          if ((bidx_q == 2'd3) || last_byte) begin
            word_d = '0;
            bidx_d = '0;
            if (req_q && !mem_ack_i) begin
              go_err = 1'b1;  // overrun
            end else begin
              wdata_d = word_nxt;
              if (req_q) pend_d = 1'b1;
              else       req_d  = 1'b1;
            end
          end
`ifdef UART_LOADER_CSUM_EN
          if (last_byte) state_d = StCsum;
`endif
        end
      end
      StCsum: begin
        if (!csum_got_q) begin
          if (rx_valid_q) begin
            csum_got_d = 1'b1;
            csum_bad_d = (rx_byte != sum_q);
          end
        end else if (wr_idle) begin
          if (csum_bad_q) go_err  = 1'b1;
          else            state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (go_err) begin
      state_d = StErr;
      err_d   = 1'b1;
      req_d   = 1'b0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_q     <= '0;
      bidx_q     <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      pend_q     <= 1'b0;
      sum_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      csum_got_q <= 1'b0;
      csum_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      bidx_q     <= bidx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      csum_got_q <= csum_got_d;
      csum_bad_q <= csum_bad_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign halt_req_o  = in_frame;
  assign reset_req_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Testbench for uart_loader: frames are sent bit by bit on rx_pin. The expected writes
// are derived from the payload bytes, and the bus monitor captures every accepted write.
module tb_uart_loader;

  localparam int unsigned ClkDiv  = 4;
  localparam int unsigned Timeout = 200;
`ifdef UART_LOADER_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_pin = 1'b1;
  logic        mem_ack_i;
  logic        mem_req_o, mem_we_o, halt_req_o, reset_req_o, busy_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  int n_checks = 0;
  int n_fail   = 0;

  int          ack_delay = 0;
  bit          ack_block = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          cap_len[$];
  int          req_len    = 0;
  int          rst_cycles = 0;
  int          halt_gap   = 0;
  int          stab_bad   = 0;
  logic [31:0] hold_addr  = '0;
  logic [31:0] hold_data  = '0;
  bit          req_prev   = 1'b0;

  uart_loader #(
    .CLK_DIV  (ClkDiv),
    .BASE_ADDR(32'h0),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_pin     (rx_pin),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .halt_req_o (halt_req_o),
    .reset_req_o(reset_req_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Bus slave: acknowledge after ack_delay waiting cycles, or never while ack_block is set.
  assign mem_ack_i = mem_req_o && !ack_block && (wait_cnt >= ack_delay);
  always @(posedge clk) wait_cnt <= (mem_req_o && !mem_ack_i) ? wait_cnt + 1 : 0;

  // Monitor on the falling edge: capture writes and check request stability.
  always @(negedge clk) begin
    if (mem_we_o !== mem_req_o) stab_bad++;
    if (mem_req_o) begin
      if (req_prev && (mem_addr_o !== hold_addr || mem_wdata_o !== hold_data)) stab_bad++;
      hold_addr = mem_addr_o;
      hold_data = mem_wdata_o;
      req_len++;
      if (mem_ack_i) begin
        cap_addr.push_back(mem_addr_o);
        cap_data.push_back(mem_wdata_o);
        cap_len.push_back(req_len);
        req_len = 0;
      end
    end else begin
      req_len = 0;
    end
    req_prev = mem_req_o && !mem_ack_i;
    if (reset_req_o) rst_cycles++;
    if (busy_o && !halt_req_o && !reset_req_o && !err_o) halt_gap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (ClkDiv) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    repeat (2) @(negedge clk);
    while (busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  task automatic clear_mon();
    cap_addr.delete();
    cap_data.delete();
    cap_len.delete();
    rst_cycles = 0;
    halt_gap   = 0;
  endtask

  // Send one complete frame and compare against words packed from the payload.
  task automatic run_frame(input string tag, input logic [7:0] pl[$], input int delay,
                           input bit bad_csum);
    int          len = pl.size();
    int          nw  = (len + 3) / 4;
    logic [7:0]  sum = 8'h00;
    logic [31:0] w;
    bit          exp_err = bad_csum && CsumEn;
    ack_delay = delay;
    clear_mon();
    send_byte(8'hA5, 1'b1);
    check({tag, "_halt_up"}, {31'b0, halt_req_o}, 32'd1);
    check({tag, "_err_clr"}, {31'b0, err_o}, 32'd0);
    send_byte(8'(len), 1'b1);
    send_byte(8'(len >> 8), 1'b1);
    foreach (pl[i]) begin
      send_byte(pl[i], 1'b1);
      sum = sum + pl[i];
    end
    if (CsumEn) send_byte(bad_csum ? sum + 8'd1 : sum, 1'b1);
    wait_idle(tag, 400);
    check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (4 * k + j < len) w = w | (32'(pl[4 * k + j]) << (8 * j));
      if (k < cap_addr.size()) begin
        check({tag, "_addr"}, cap_addr[k], 32'(4 * k));
        check({tag, "_data"}, cap_data[k], w);
        check({tag, "_reqlen"}, 32'(cap_len[k]), 32'(delay + 1));
      end
    end
    check({tag, "_rstpulse"}, 32'(rst_cycles), exp_err ? 32'd0 : 32'd1);
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    check({tag, "_halt_gap"}, 32'(halt_gap), 32'd0);
    check({tag, "_halt_end"}, {31'b0, halt_req_o}, 32'd0);
  endtask

  task automatic rand_payload(output logic [7:0] pl[$]);
    int n = $urandom_range(1, 12);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];

    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    check("rst_halt", {31'b0, halt_req_o}, 32'd0);
    check("rst_rreq", {31'b0, reset_req_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("frame_a", pl, 0, 1'b0);
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("len5", pl, 0, 1'b0);
    pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("ack3", pl, 3, 1'b0);
    for (int r = 0; r < 5; r++) begin
      rand_payload(pl);
      run_frame("rand", pl, int'($urandom_range(0, 3)), 1'b0);
    end
    if (CsumEn) begin
      pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame("badsum", pl, 0, 1'b1);
    end

    // Overrun: the first word is never acknowledged when the second word is ready.
    clear_mon();
    ack_delay = 0;
    ack_block = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    wait_idle("ovr", 400);
    check("ovr_err", {31'b0, err_o}, 32'd1);
    check("ovr_req", {31'b0, mem_req_o}, 32'd0);
    check("ovr_nwrites", 32'(cap_addr.size()), 32'd0);
    check("ovr_rstpulse", 32'(rst_cycles), 32'd0);
    ack_block = 1'b0;

    // Sync clears the sticky error; then an idle line times out.
    send_byte(8'hA5, 1'b1);
    check("tmo_err_clr", {31'b0, err_o}, 32'd0);
    check("tmo_halt", {31'b0, halt_req_o}, 32'd1);
    repeat (Timeout + 60) @(negedge clk);
    check("tmo_err", {31'b0, err_o}, 32'd1);
    check("tmo_busy", {31'b0, busy_o}, 32'd0);
    check("tmo_halt_end", {31'b0, halt_req_o}, 32'd0);

    // Non-sync bytes in IDLE are ignored.
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h12, 1'b1);
    check("junk_busy", {31'b0, busy_o}, 32'd0);
    check("junk_halt", {31'b0, halt_req_o}, 32'd0);
    check("junk_nwrites", 32'(cap_addr.size()), 32'd0);

    // Framing error inside DATA.
    clear_mon();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    wait_idle("ferr", 100);
    check("ferr_err", {31'b0, err_o}, 32'd1);
    check("ferr_rstpulse", 32'(rst_cycles), 32'd0);
    check("ferr_nwrites", 32'(cap_addr.size()), 32'd0);

    // One-cycle low glitch in IDLE.
    @(negedge clk);
    rx_pin = 1'b0;
    @(negedge clk);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", {31'b0, busy_o}, 32'd0);
    rand_payload(pl);
    run_frame("post_glitch", pl, 1, 1'b0);

    // Reset mid-payload while a write is outstanding.
    ack_block = 1'b1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 1'b1);
    check("mid_req", {31'b0, mem_req_o}, 32'd1);
    check("mid_halt", {31'b0, halt_req_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_req_o}, 32'd0);
    check("arst_halt", {31'b0, halt_req_o}, 32'd0);
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_wdata", mem_wdata_o, 32'd0);
    check("arst_addr", mem_addr_o, 32'd0);
    check("arst_rreq", {31'b0, reset_req_o}, 32'd0);
    check("arst_err", {31'b0, err_o}, 32'd0);
    @(negedge clk);
    ack_block = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rand_payload(pl);
    run_frame("post_rst", pl, 2, 1'b0);

    check("bus_stability", 32'(stab_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
